// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
// Removes a 1..DATA_BYTE_WD byte header from the front of each AXI-Stream
// packet. The first beat goes out unmodified on the header side channel; the
// remaining bytes are realigned to the MSB and sent on the payload stream.
// Header and body beats pass through combinationally. Only the trailing FLUSH
// beat is produced from registered state.
module axi_stream_strip_header #(
    parameter int DATA_WD = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [DATA_WD-1:0]            data_in,
    input  logic [DATA_WD/8-1:0]          keep_in,
    input  logic                          last_in,
    input  logic                          valid_strip,
    output logic                          ready_strip,
    input  logic [$clog2(DATA_WD/8)-1:0]  byte_strip_cnt,
    output logic                          valid_hdr,
    input  logic                          ready_hdr,
    output logic [DATA_WD-1:0]            data_hdr,
    output logic [DATA_WD/8-1:0]          keep_hdr,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [DATA_WD-1:0]            data_out,
    output logic [DATA_WD/8-1:0]          keep_out,
    output logic                          last_out
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
    localparam int CW           = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_FLUSH} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_n;
    logic [CW-1:0]       r_cache_cnt;
    logic [DATA_WD-1:0]  r_cache;

    logic [DATA_WD-1:0]  w_din_m;
    logic [DATA_WD-1:0]  w_shl_n;
    logic [DATA_WD-1:0]  w_shr_r;
    logic [CW-1:0]       w_k;
    logic [CW-1:0]       w_r;
    logic [CW-1:0]       w_k_minus_n;
    logic                w_k_gt_n;
    logic                w_in_hs;
    int                  w_nbits;
    int                  w_rbits;

    // Mask with the top n byte lanes set (byte 0 sits at the MSB end).
    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < int'(n)) m[DATA_BYTE_WD-1-i] = 1'b1;
        end
        return m;
    endfunction

    // Number of enabled bytes in a keep vector.
    function automatic logic [CW-1:0] pop_count(input logic [DATA_BYTE_WD-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
        return c;
    endfunction

    // Zero every byte lane whose keep bit is clear so unused output bytes read 0.
    function automatic logic [DATA_WD-1:0] keep_bytes(input logic [DATA_WD-1:0] d,
                                                      input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] r;
        r = d;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (!k[i]) r[i*8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    assign w_din_m     = keep_bytes(data_in, keep_in);
    assign w_k         = pop_count(keep_in);
    assign w_r         = CW'(DATA_BYTE_WD) - r_n;
    assign w_k_gt_n    = (w_k > r_n);
    assign w_k_minus_n = w_k - r_n;
    assign w_nbits     = int'(r_n) * 8;
    assign w_rbits     = int'(w_r) * 8;
    // Bytes N..W-1 moved to the MSB end: the residue carried to the next beat.
    assign w_shl_n     = w_din_m << w_nbits;
    // Top N bytes moved down to sit just below the R cached bytes.
    assign w_shr_r     = w_din_m >> w_rbits;
    assign w_in_hs     = valid_in && ready_in;

    // Handshake and data outputs decoded from the current state.
    always_comb begin
        ready_strip = 1'b0;
        ready_in    = 1'b0;
        valid_hdr   = 1'b0;
        data_hdr    = '0;
        keep_hdr    = '0;
        valid_out   = 1'b0;
        data_out    = '0;
        keep_out    = '0;
        last_out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_strip = 1'b1;
            end
            S_HDR: begin
                valid_hdr = valid_in;
                data_hdr  = data_in;
                keep_hdr  = keep_in & top_mask(r_n);
                ready_in  = ready_hdr;
            end
            S_BODY: begin
                valid_out = valid_in;
                ready_in  = ready_out;
                data_out  = r_cache | w_shr_r;
                if (last_in && !w_k_gt_n) begin
                    keep_out = top_mask(w_r + w_k);
                    last_out = 1'b1;
                end else begin
                    keep_out = '1;
                end
            end
            S_FLUSH: begin
                valid_out = 1'b1;
                data_out  = r_cache;
                keep_out  = top_mask(r_cache_cnt);
                last_out  = 1'b1;
            end
            default: ;
        endcase
    end

    // Packet sequencing, header length latch and residual byte cache.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_cache     <= '0;
            r_cache_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_strip) begin
                        r_n     <= {1'b0, byte_strip_cnt} + CW'(1);
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_in_hs) begin
                        r_cache     <= w_shl_n;
                        r_cache_cnt <= w_k_gt_n ? w_k_minus_n : '0;
                        if (last_in && w_k_gt_n) r_state <= S_FLUSH;
                        else if (last_in)        r_state <= S_IDLE;
                        else                     r_state <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_in_hs) begin
                        r_cache <= w_shl_n;
                        if (last_in && w_k_gt_n) begin
                            r_cache_cnt <= w_k_minus_n;
                            r_state     <= S_FLUSH;
                        end else if (last_in) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (ready_out) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Testbench for axi_stream_strip_header: table of packet shapes plus
// hand-written corner sequences, checked by a byte-level scoreboard.
module tb_axi_stream_strip_header;
    localparam int W  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid_in, ready_in, last_in;
    logic [DW-1:0] data_in;
    logic [W-1:0]  keep_in;
    logic          valid_strip, ready_strip;
    logic [1:0]    byte_strip_cnt;
    logic          valid_hdr, ready_hdr;
    logic [DW-1:0] data_hdr;
    logic [W-1:0]  keep_hdr;
    logic          valid_out, ready_out, last_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk(clk), .rstn(rstn),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .keep_in(keep_in), .last_in(last_in),
        .valid_strip(valid_strip), .ready_strip(ready_strip),
        .byte_strip_cnt(byte_strip_cnt),
        .valid_hdr(valid_hdr), .ready_hdr(ready_hdr),
        .data_hdr(data_hdr), .keep_hdr(keep_hdr),
        .valid_out(valid_out), .ready_out(ready_out),
        .data_out(data_out), .keep_out(keep_out), .last_out(last_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [W-1:0]  keep;
        logic          last;
    } beat_t;

    typedef struct {
        int           cnt;
        int           len;
        bit           rnd;
        int           exp_beats;
        logic [W-1:0] exp_last_keep;
    } vec_t;

    beat_t        exp_out_q[$];
    beat_t        exp_hdr_q[$];
    vec_t         vecs[9];
    int           checks = 0;
    int           failures = 0;
    int           out_cnt = 0;
    logic [W-1:0] last_keep_seen = '0;
    bit           rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] tmask(input int n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) if (i < n) m[W-1-i] = 1'b1;
        return m;
    endfunction

    task automatic push_hdr(input logic [DW-1:0] d, input logic [W-1:0] k);
        beat_t b;
        b.data = d; b.keep = k; b.last = 1'b0;
        exp_hdr_q.push_back(b);
    endtask

    task automatic push_out(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        exp_out_q.push_back(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready_strip"}, 32'(ready_strip), 1);
        chk({tag, "_ready_in"},    32'(ready_in), 0);
        chk({tag, "_valid_hdr"},   32'(valid_hdr), 0);
        chk({tag, "_valid_out"},   32'(valid_out), 0);
        chk({tag, "_last_out"},    32'(last_out), 0);
        chk({tag, "_data_out"},    data_out, 0);
        chk({tag, "_keep_out"},    32'(keep_out), 0);
        chk({tag, "_data_hdr"},    data_hdr, 0);
        chk({tag, "_keep_hdr"},    32'(keep_hdr), 0);
    endtask

    // Issue a strip command; starts and ends at posedge+1.
    task automatic drive_cmd(input int cnt);
        int i;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(cnt);
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (ready_strip !== 1'b1 && i < 50);
        chk("cmd_accept", 32'(ready_strip === 1'b1), 1);
        @(posedge clk); #1;
        valid_strip = 1'b0;
    endtask

    // Present one input beat and hold it until accepted; starts and ends at posedge+1.
    task automatic drive_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
        int i;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (ready_in !== 1'b1 && i < 100);
        chk("beat_accept", 32'(ready_in === 1'b1), 1);
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    // Build expected header/payload from a byte model, then drive the packet.
    task automatic run_pkt(input int cnt, input int len, input int id);
        logic [7:0]    pkt [0:63];
        logic [DW-1:0] d;
        int            n, nb, p, nn, idx;
        n  = cnt + 1;
        nb = (len + W - 1) / W;
        for (int i = 0; i < len; i++) pkt[i] = 8'(id * 37 + i * 5 + 1);
        d = '0;
        for (int j = 0; j < W; j++) d[DW-1-8*j -: 8] = (j < len) ? pkt[j] : 8'hEE;
        push_hdr(d, tmask(len < W ? len : W) & tmask(n));
        p = (len > n) ? len - n : 0;
        for (int o = 0; o < p; o += W) begin
            nn = (p - o < W) ? p - o : W;
            d = '0;
            for (int j = 0; j < nn; j++) d[DW-1-8*j -: 8] = pkt[n+o+j];
            push_out(d, tmask(nn), (o + W >= p));
        end
        @(posedge clk); #1;
        drive_cmd(cnt);
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < W; j++) begin
                idx = b * W + j;
                d[DW-1-8*j -: 8] = (idx < len) ? pkt[idx] : 8'hEE;
            end
            drive_beat(d, tmask((len - b * W) < W ? (len - b * W) : W), (b == nb - 1));
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((exp_out_q.size() != 0 || exp_hdr_q.size() != 0 || ready_strip !== 1'b1) && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_drain_in_time"}, 32'(i < 200), 1);
        chk({tag, "_queues_empty"}, 32'(exp_out_q.size() + exp_hdr_q.size()), 0);
    endtask

    // Ready generator for the two downstream channels.
    initial begin
        ready_out = 1'b1;
        ready_hdr = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rnd_mode) begin
                ready_out = ($urandom_range(0, 1) == 1);
                ready_hdr = ($urandom_range(0, 1) == 1);
            end else begin
                ready_out = 1'b1;
                ready_hdr = 1'b1;
            end
        end
    end

    // Monitor: pop and compare on each handshake, check hold-stability while stalled.
    initial begin
        beat_t         e;
        bit            stall;
        logic [DW-1:0] sd;
        logic [W-1:0]  sk;
        logic          sl;
        stall = 1'b0; sd = '0; sk = '0; sl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 32'(valid_out), 1);
                    chk("stall_data", data_out, sd);
                    chk("stall_keep_last", {27'd0, sk, sl}, {27'd0, keep_out, last_out});
                end
                stall = valid_out && !ready_out;
                sd = data_out; sk = keep_out; sl = last_out;
                if (valid_out && ready_out) begin
                    out_cnt++;
                    last_keep_seen = keep_out;
                    if (exp_out_q.size() == 0) begin
                        chk("out_unexpected_beat", data_out, 32'hDEADBEEF);
                    end else begin
                        e = exp_out_q.pop_front();
                        chk("out_data", data_out, e.data);
                        chk("out_keep", 32'(keep_out), 32'(e.keep));
                        chk("out_last", 32'(last_out), 32'(e.last));
                    end
                end
                if (valid_hdr && ready_hdr) begin
                    if (exp_hdr_q.size() == 0) begin
                        chk("hdr_unexpected_beat", data_hdr, 32'hDEADBEEF);
                    end else begin
                        e = exp_hdr_q.pop_front();
                        chk("hdr_data", data_hdr, e.data);
                        chk("hdr_keep", 32'(keep_hdr), 32'(e.keep));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rstn = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_strip = 1'b0; byte_strip_cnt = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        //             cnt len rnd beats last_keep
        vecs[0] = '{1, 10, 1'b0, 2, 4'b1111};
        vecs[1] = '{1, 11, 1'b0, 3, 4'b1000};
        vecs[2] = '{3, 10, 1'b0, 2, 4'b1100};
        vecs[3] = '{0,  1, 1'b0, 0, 4'b0000};
        vecs[4] = '{2, 24, 1'b1, 6, 4'b1000};
        vecs[5] = '{0,  4, 1'b0, 1, 4'b1110};
        vecs[6] = '{3,  2, 1'b0, 0, 4'b0000};
        vecs[7] = '{2,  7, 1'b0, 1, 4'b1111};
        vecs[8] = '{1, 13, 1'b1, 3, 4'b1110};

        for (int v = 0; v < 9; v++) begin
            out_cnt  = 0;
            rnd_mode = vecs[v].rnd;
            run_pkt(vecs[v].cnt, vecs[v].len, v + 1);
            drain($sformatf("v%0d", v));
            rnd_mode = 1'b0;
            chk($sformatf("v%0d_beats", v), 32'(out_cnt), 32'(vecs[v].exp_beats));
            if (vecs[v].exp_beats > 0)
                chk($sformatf("v%0d_last_keep", v), 32'(last_keep_seen), 32'(vecs[v].exp_last_keep));
        end

        // N=2, last beat C0C1 exactly fills the payload.
        push_hdr(32'hA0A1A2A3, 4'b1100);
        push_out(32'hA2A3B0B1, 4'b1111, 1'b0);
        push_out(32'hB2B3C0C1, 4'b1111, 1'b1);
        @(posedge clk); #1;
        drive_cmd(1);
        drive_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
        drive_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
        drive_beat(32'hC0C1EEEE, 4'b1100, 1'b1);
        drain("exact");

        // N=2, last beat C0C1C2 spills one byte into a registered FLUSH beat.
        push_hdr(32'hA0A1A2A3, 4'b1100);
        push_out(32'hA2A3B0B1, 4'b1111, 1'b0);
        push_out(32'hB2B3C0C1, 4'b1111, 1'b0);
        push_out(32'hC2000000, 4'b1000, 1'b1);
        @(posedge clk); #1;
        drive_cmd(1);
        drive_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
        drive_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
        drive_beat(32'hC0C1C2EE, 4'b1110, 1'b1);
        chk("flush_valid", 32'(valid_out), 1);
        chk("flush_ready_in", 32'(ready_in), 0);
        chk("flush_data", data_out, 32'hC2000000);
        chk("flush_keep_last", {27'd0, keep_out, last_out}, {27'd0, 4'b1000, 1'b1});
        drain("flush");

        // N=1 header-only packet, then a command right after the single bubble.
        push_hdr(32'hA0EEEEEE, 4'b1000);
        @(posedge clk); #1;
        drive_cmd(0);
        drive_beat(32'hA0EEEEEE, 4'b1000, 1'b1);
        chk("bubble_ready_strip", 32'(ready_strip), 1);
        chk("bubble_no_out", 32'(valid_out), 0);
        push_hdr(32'h11223344, 4'b1111);
        drive_cmd(3);
        drive_beat(32'h11223344, 4'b1111, 1'b1);
        drain("bubble");

        // Asynchronous reset in the middle of BODY.
        push_hdr(32'h01020304, 4'b1100);
        push_out(32'h03040506, 4'b1111, 1'b0);
        @(posedge clk); #1;
        drive_cmd(1);
        drive_beat(32'h01020304, 4'b1111, 1'b0);
        drive_beat(32'h05060708, 4'b1111, 1'b0);
        valid_in = 1'b1; data_in = 32'h090A0B0C; keep_in = 4'b1111; last_in = 1'b0;
        #2;
        chk("pre_reset_body_valid", 32'(valid_out), 1);
        chk("pre_reset_body_data", data_out, 32'h0708090A);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        valid_in = 1'b0;
        chk("midrst_queues_empty", 32'(exp_out_q.size() + exp_hdr_q.size()), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        out_cnt = 0;
        run_pkt(1, 10, 42);
        drain("post_rst");
        chk("post_rst_beats", 32'(out_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Removes a variable-length header (1..DATA_BYTE_WD bytes) from the front of each AXI-Stream packet. It emits the header on a side channel and the byte-realigned payload on the output stream. It is the receive-side counterpart of the header-insertion stage and sits between the link receiver and payload consumers. One packet is processed per strip command.

## Interface
- DATA_WD, 32: stream data width in bits, multiple of 8.
- DATA_BYTE_WD, DATA_WD/8 (localparam): bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD) (localparam): width of the strip count.

Ports:
- clk  in  1  clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- valid_in / ready_in  in / out  1  input stream handshake.
- data_in  in  DATA_WD  input data; byte 0 = data_in[DATA_WD-1 -: 8] (MSB first).
- keep_in  in  DATA_BYTE_WD  byte enables, contiguous from MSB; non-contiguous is don't-care.
- last_in  in  1  last beat of packet.
- valid_strip / ready_strip  in / out  1  strip command handshake.
- byte_strip_cnt  in  BYTE_CNT_WD  header length N minus 1 (N = cnt+1, computed in BYTE_CNT_WD+1 bits).
- valid_hdr / ready_hdr  out / in  1  header side-channel handshake.
- data_hdr  out  DATA_WD  first beat of packet, unmodified.
- keep_hdr  out  DATA_BYTE_WD  keep_in of first beat AND top-N mask.
- valid_out / ready_out  out / in  1  payload stream handshake.
- data_out, keep_out, last_out  out  DATA_WD, DATA_BYTE_WD, 1  realigned payload; keep MSB-aligned; unused bytes are 0.

## Operation
- Definitions: R = DATA_BYTE_WD − N residual bytes; k = popcount(keep_in).
- States and per-state behaviour:
  - IDLE: ready_strip=1, all other handshake outputs 0.
    - On valid_strip: latch N and go to HDR.
  - HDR: valid_hdr=valid_in, data_hdr=data_in, ready_in=ready_hdr.
    - On the input handshake, cache ← bytes N..W-1 of data_in and cache_cnt ← max(k−N,0).
    - If last_in and k>N: go to FLUSH.
    - Else if last_in: go to IDLE. The packet is header-only; a short header is flagged by keep_hdr having fewer than N ones.
    - Else: go to BODY.
  - BODY: valid_out=valid_in and ready_in=ready_out (combinational).
    - data_out = cache (R bytes, MSB) followed by top N bytes of data_in.
    - On a non-last beat: keep_out all ones, last_out=0, cache ← low R bytes.
    - On last_in with k≤N: keep count R+k, last_out=1, go to IDLE.
    - On last_in with k>N: keep all ones, last_out=0, cache_cnt ← k−N, go to FLUSH.
  - FLUSH: ready_in=0, valid_out=1, data_out = cache at MSB, zeros below, keep count cache_cnt, last_out=1.
    - On ready_out: go to IDLE.
- N = DATA_BYTE_WD (R=0): BODY is pure pass-through and FLUSH is never entered.
- Non-last beats must carry full keep; otherwise the result is undefined.

## Timing
- Reset: state IDLE, cache and cache_cnt 0, N latch 0.
  - Outputs after reset: ready_strip=1; ready_in, valid_hdr, valid_out, last_out = 0; data and keep outputs 0.
- Latency:
  - Strip command to HDR: 1 cycle.
  - Header and BODY payload: 0 cycles (combinational from valid_in/data_in).
  - FLUSH beat: registered, the cycle after the last input handshake.
- After each packet the block returns to IDLE, so there is exactly one bubble cycle before ready_strip=1 for the next command.
- Data held under backpressure:
  - valid_out, data_out, keep_out and last_out stay stable while valid_out=1 and ready_out=0, provided the input is held per AXI rules.
  - FLUSH output is register-held.
- Simultaneous events:
  - valid_strip outside IDLE is ignored (ready_strip=0).
  - Input beats in IDLE are not accepted (ready_in=0).
- Reset mid-packet: return to IDLE immediately. Buffered bytes are discarded and no partial beat is emitted.

## Test plan
- W=4 bytes, cnt=1 (N=2); input A0..A3, B0..B3, then C0C1 with keep 1100 and last.
  - Header A0A1A2A3 with keep 1100.
  - Payload A2A3B0B1 keep 1111, then B2B3C0C1 keep 1111 with last.
- Same packet but C0C1C2 with keep 1110 and last.
  - Payload B2B3C0C1 keep 1111 without last, then C2 000000 keep 1000 with last on the next cycle (FLUSH).
- cnt=3 (N=4); beats A, B, C (last, keep 1100).
  - Header A with keep 1111.
  - Payload is B and C unchanged, keep 1111 then 1100 with last.
- cnt=0 (N=1); single beat A0 with keep 1000 and last.
  - Header keep 1000, no payload beat, state returns to IDLE.
  - A second command is accepted two cycles later.
- ready_out is toggled randomly 50% during a 6-beat packet at N=3.
  - Output beats match the reference byte stream exactly.
  - No beat is dropped or duplicated.
  - Outputs are stable while stalled.
- rstn is asserted in the middle of BODY.
  - All outputs return to their reset values asynchronously.
  - The next packet strips correctly.
